alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter S, default 4: slice width in bits.
REQ-002 Parameter N_A, default 2: number of slices; W = N_A*S is the datapath width.
REQ-003 Parameter CW, default $clog2(N_A*S)+1: shift-count width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 cmd_op  in  3  000 ADD, 001 SHR, 010 POPCOUNT, 011 CMP; 1xx reserved.
REQ-009 cmd_a, cmd_b  in  W  operands.
REQ-010 cmd_cnt  in  CW  SHR shift amount; ignored for other ops.
REQ-011 alu_op  out  3  op driven to the slices and the interconnect.
REQ-012 alu_a, alu_b  out  W  operands driven to the slices.
REQ-013 alu_out  in  W  combinational final_out from the interconnect.
REQ-014 alu_cmp  in  2  combinational final_cmp from the interconnect.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts the result.
REQ-017 res_data  out  W  result word.
REQ-018 res_cmp  out  2  compare code; 00 for non-CMP ops.
REQ-019 res_err  out  1  set for reserved opcodes.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, EXEC, DONE; exactly one active.
REQ-022 cmd_ready SHALL equal (state==IDLE); no command is accepted in EXEC or DONE.
REQ-023 On acceptance, latch op/a/b; iteration count = 1 for ADD and CMP, cmd_cnt for SHR, N_A for POPCOUNT; next state EXEC.
REQ-024 Reserved op, or SHR with cmd_cnt==0: skip EXEC; next state DONE; res_data=cmd_a, res_cmp=00; res_err=1 only for a reserved op.
REQ-025 In EXEC: alu_op=latched op, alu_a=working A, alu_b=latched B; each cycle decrement remaining count and load working A <= alu_out.
REQ-026 When remaining==1 in EXEC: capture alu_out into res_data and alu_cmp into res_cmp (CMP only, else 00); next state DONE.
REQ-027 Latency: ADD/CMP result valid 2 cycles after the acceptance edge; SHR with count k valid k+1 cycles after; POPCOUNT valid N_A+1 cycles after.
REQ-028 In IDLE and DONE, alu_op=000, alu_a=0, alu_b=0.
REQ-029 DONE: res_valid=1; res_data/res_cmp/res_err held stable until res_valid & res_ready; then next state IDLE.
REQ-030 res_ready is ignored outside DONE; cmd_valid is ignored outside IDLE.
REQ-031 Counter is CW bits wide; SHR counts above W are saturated to W (result 0 for a logical shift).

Reset
REQ-032 rst asserts asynchronously: state=IDLE, res_valid=0, res_data=0, res_cmp=00, res_err=0, count=0, busy=0, alu_* outputs=0.
REQ-033 Reset mid-EXEC or mid-DONE discards the operation; no result is emitted after deassertion.
REQ-034 First command may be accepted on the first rising edge after rst deasserts.

Structure
REQ-035 Opcode constants (ADD, SHR, POPCOUNT, CMP) and FSM state encodings SHALL live in the shared ALU package used by the slices and the interconnect.
REQ-036 Single module with no sub-modules; slices and interconnect are instantiated beside it at the ALU top level.

Verification (S=4, N_A=2, real slices and interconnect)
REQ-037 ADD a=0x3C b=0x05, res_ready=1 -> res_data=0x41, res_cmp=00, res_valid 2 cycles after accept.
REQ-038 SHR a=0xB4 cnt=3 -> res_data=0x16 after 4 cycles; cnt=0 -> res_data=0xB4 with no EXEC cycle.
REQ-039 CMP a=0x12 b=0x34 -> res_cmp equals interconnect code for a<b; a=b=0x55 -> res_cmp=00.
REQ-040 res_ready held low 5 cycles in DONE -> res_data stable and cmd_ready=0 throughout; IDLE one cycle after the handshake.
REQ-041 rst pulsed during the 2nd cycle of SHR cnt=5 -> outputs at reset values immediately; no res_valid afterwards; next command executes correctly.
REQ-042 cmd_op=101 -> res_err=1, res_data=cmd_a, res_valid 1 cycle after accept.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer state encodings and
// small opcode helpers used by the sequencer, the slices and the interconnect.
package alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD      = 3'b000,
    OP_SHR      = 3'b001,
    OP_POPCOUNT = 3'b010,
    OP_CMP      = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  localparam logic [1:0] CMP_NONE = 2'b00;

  // Every opcode with the top bit set is reserved.
  function automatic logic op_reserved(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: accepts one command, iterates the external slice
// array through alu_op/alu_a/alu_b, and holds the result until it is consumed.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int S   = 4,
  parameter int N_A = 2,
  parameter int CW  = $clog2(N_A*S) + 1,
  localparam int W  = N_A*S
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  input  logic [CW-1:0] cmd_cnt,

  output logic [2:0]    alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_out,
  input  logic [1:0]    alu_cmp,

  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic [1:0]    res_cmp,
  output logic          res_err,
  output logic          busy
);

  seq_state_e    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic [1:0]    res_cmp_q, res_cmp_d;
  logic          res_err_q, res_err_d;

  logic [CW-1:0] shr_cnt;
  logic [CW-1:0] iter_cnt;
  logic          skip_exec;

  // Shift counts beyond the datapath width behave like a full-width shift.
  assign shr_cnt   = (cmd_cnt > CW'(W)) ? CW'(W) : cmd_cnt;
  assign skip_exec = op_reserved(cmd_op) || ((cmd_op == OP_SHR) && (cmd_cnt == '0));

  always_comb begin
    iter_cnt = '0;
    case (cmd_op)
      OP_ADD, OP_CMP: iter_cnt = CW'(1);
      OP_SHR:         iter_cnt = shr_cnt;
      OP_POPCOUNT:    iter_cnt = CW'(N_A);
      default:        iter_cnt = '0;
    endcase
  end

  // NOTE: every variable gets its hold value before the case, so no branch
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_cmp_d  = res_cmp_q;
    res_err_d  = res_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          a_d  = cmd_a;
          b_d  = cmd_b;
          if (skip_exec) begin
            cnt_d      = '0;
            res_data_d = cmd_a;
            res_cmp_d  = CMP_NONE;
            res_err_d  = op_reserved(cmd_op);
            state_d    = ST_DONE;
          end else begin
            cnt_d     = iter_cnt;
            res_err_d = 1'b0;
            state_d   = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        cnt_d = cnt_q - CW'(1);
        a_d   = alu_out;
        if (cnt_q == CW'(1)) begin
          res_data_d = alu_out;
          res_cmp_d  = (op_q == OP_CMP) ? alu_cmp : CMP_NONE;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_cmp_q  <= CMP_NONE;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_cmp_q  <= res_cmp_d;
      res_err_q  <= res_err_d;
    end
  end

  // The slices only see live operands while iterating; elsewhere they idle at 0.
  always_comb begin
    alu_op = OP_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (state_q == ST_EXEC) begin
      alu_op = op_q;
      alu_a  = a_q;
      alu_b  = b_q;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_data_q;
  assign res_cmp   = res_cmp_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural stand-in for the slice array;
// a scoreboard queue links the command driver to the result monitor.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam int S   = 4;
  localparam int N_A = 2;
  localparam int W   = N_A*S;
  localparam int CW  = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [CW-1:0] cmd_cnt;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [1:0]    alu_cmp;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_data;
  logic [1:0]    res_cmp;
  logic          res_err, busy;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   cmp;
    logic         err;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rr_hold = 0;
  bit   rr_rand = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl #(.S(S), .N_A(N_A)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cmp(alu_cmp),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cmp(res_cmp), .res_err(res_err), .busy(busy)
  );

  function automatic logic [W-1:0] popcnt(input logic [W-1:0] x);
    logic [W-1:0] n = '0;
    for (int i = 0; i < W; i++) n += W'(x[i]);
    return n;
  endfunction

  // Stand-in for slices + interconnect: one step of each op per cycle.
  always_comb begin
    alu_out = '0;
    alu_cmp = 2'b00;
    case (alu_op)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a >> 1;
      3'b010: alu_out = popcnt(alu_a);
      3'b011: begin
        alu_out = alu_a ^ alu_b;
        alu_cmp = (alu_a == alu_b) ? 2'b00 : ((alu_a < alu_b) ? 2'b01 : 2'b10);
      end
      default: alu_out = '0;
    endcase
  end

  // Reference: whole-operation results and latency counted from the accept cycle.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b,
                                 input logic [CW-1:0] cnt);
    exp_t e;
    int   k;
    logic [W-1:0] x;
    e.data = a; e.cmp = 2'b00; e.err = 1'b0; e.lat = 1; e.acc_cyc = 0;
    case (op)
      3'b000: begin e.data = a + b; e.lat = 2; end
      3'b001: begin
        k = (int'(cnt) > W) ? W : int'(cnt);
        e.data = (k >= W) ? '0 : (a >> k);
        e.lat  = k + 1;
      end
      3'b010: begin
        x = a;
        for (int i = 0; i < N_A; i++) x = popcnt(x);
        e.data = x;
        e.lat  = N_A + 1;
      end
      3'b011: begin
        e.data = a ^ b;
        e.cmp  = (a == b) ? 2'b00 : ((a < b) ? 2'b01 : 2'b10);
        e.lat  = 2;
      end
      default: begin e.data = a; e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b,
                       input logic [CW-1:0] cnt);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cnt = cnt;
    while (!cmd_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    e = model(op, a, b, cnt);
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_cnt = CW'($urandom);
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((sb_q.size() != 0 || busy) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: drives res_ready, then checks what the next edge will see.
  initial begin
    logic [W+2:0] held;
    bit was_valid   = 1'b0;
    bit expect_idle = 1'b0;
    exp_t e;
    res_ready = 1'b1;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        was_valid   = 1'b0;
        expect_idle = 1'b0;
      end else begin
        if (res_valid && rr_hold > 0) begin
          res_ready = 1'b0;
          rr_hold--;
        end else begin
          res_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("cmd_ready_vs_busy", 64'(cmd_ready), 64'(!busy));
        if (expect_idle) begin
          check("idle_after_handshake", 64'(cmd_ready), 64'd1);
          expect_idle = 1'b0;
        end
        if (!busy || res_valid)
          check("alu_quiet", {alu_op, alu_a, alu_b}, 64'd0);
        if (res_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_result", 64'(res_valid), 64'd0);
          end else begin
            if (!was_valid) begin
              check("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(sb_q[0].lat));
              held = {res_err, res_cmp, res_data};
            end else begin
              check("held_stable", {res_err, res_cmp, res_data}, held);
            end
            if (res_ready) begin
              e = sb_q.pop_front();
              check("res_data", res_data, e.data);
              check("res_cmp", res_cmp, e.cmp);
              check("res_err", res_err, e.err);
              expect_idle = 1'b1;
            end
          end
        end
        was_valid = res_valid && !res_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0]    op;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cnt = '0;
    #1;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_cmp_err", {res_cmp, res_err}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(OP_ADD, 8'h3C, 8'h05, '0);
    issue(OP_SHR, 8'hB4, 8'h00, 4'd3);
    issue(OP_SHR, 8'hB4, 8'h00, 4'd0);
    issue(OP_CMP, 8'h12, 8'h34, '0);
    issue(OP_CMP, 8'h55, 8'h55, '0);
    issue(OP_CMP, 8'h90, 8'h21, '0);
    issue(3'b101, 8'hA7, 8'h11, '0);
    issue(3'b111, 8'h3E, 8'h00, 4'd2);
    issue(OP_POPCOUNT, 8'hFF, 8'h00, '0);
    issue(OP_POPCOUNT, 8'hB4, 8'h00, '0);
    issue(OP_SHR, 8'hFF, 8'h00, 4'd8);
    issue(OP_SHR, 8'hFF, 8'h00, 4'd15);
    issue(OP_ADD, 8'hFF, 8'h02, '0);

    // Consumer stalls for five DONE cycles.
    wait_drain();
    rr_hold = 5;
    issue(OP_ADD, 8'h21, 8'h43, '0);
    wait_drain();

    // Reset in the second EXEC cycle of a five-step shift.
    issue(OP_SHR, 8'hB4, 8'h00, 4'd5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_res_valid", 64'(res_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_res", {res_err, res_cmp, res_data}, 64'd0);
    check("midrst_alu", {alu_op, alu_a, alu_b}, 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_result_after_rst", 64'(res_valid), 64'd0);
    issue(OP_SHR, 8'hB4, 8'h00, 4'd2);
    wait_drain();

    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      issue(op, W'($urandom), W'($urandom), CW'($urandom));
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
